// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
//   Bundle of the fetch-stage signals shared between the fetch unit, the
//   instruction memory and the decode stage.
//
//   Signals:
//     stall          hold the PC and the output registers
//     branch_taken   PC-relative redirect request (relative to pc_out)
//     branch_offset  signed two's-complement branch offset
//     jump           absolute redirect request
//     jump_target    absolute redirect target
//     address        word address to the instruction memory (the PC register)
//     ins            instruction word returned by the memory
//     ins_out        registered instruction for decode
//     pc_out         PC of ins_out
//     valid          ins_out/pc_out hold a real instruction
//     halted         fetch has stopped on an all-zero word
//     fetch_cnt      saturating count of valid captures
//
//   Modports:
//     slave   the fetch unit's view
//     master  the environment's view (decode, memory, testbench)
// -----------------------------------------------------------------------------
interface pc_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_offset;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] ins;
  logic [DATA_W-1:0] ins_out;
  logic [ADDR_W-1:0] pc_out;
  logic              valid;
  logic              halted;
  logic [15:0]       fetch_cnt;

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_offset,
    input  jump,
    input  jump_target,
    input  ins,
    output address,
    output ins_out,
    output pc_out,
    output valid,
    output halted,
    output fetch_cnt
  );

  modport master (
    output stall,
    output branch_taken,
    output branch_offset,
    output jump,
    output jump_target,
    output ins,
    input  address,
    input  ins_out,
    input  pc_out,
    input  valid,
    input  halted,
    input  fetch_cnt
  );
endinterface : pc_fetch_if

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Instruction-fetch front end. Holds the program counter, presents it as
//   the word address of a combinational instruction memory, and registers
//   the returned word with its PC for decode. Supports stall, PC-relative
//   branch, absolute jump and (optionally) halt on an all-zero word.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pc_fetch_if.slave (control inputs, memory address/data,
//            registered instruction, pc_out, valid, halted, fetch_cnt)
//
//   Parameters:
//     ADDR_W    PC / word-address width
//     DATA_W    instruction width
//     RESET_PC  PC loaded on reset
//
//   Configuration macro:
//     PC_FETCH_HALT_EN  when defined, an all-zero fetched word stops fetch
//                       in the HALTED state (left only by reset). When
//                       undefined, zero words are ordinary instructions and
//                       halted is tied low.
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_fetch_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);
  localparam logic [15:0]       LP_CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ins_out;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_valid;
  logic [15:0]       r_fetch_cnt;

  // Next-state values
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_ins_out_nxt;
  logic [ADDR_W-1:0] w_pc_out_nxt;
  logic              w_valid_nxt;
  logic [15:0]       w_fetch_cnt_nxt;

  // Decoded control
  logic              w_run;
  logic              w_adv;
  logic              w_jump;
  logic              w_branch;
  logic              w_redirect;
  logic              w_zero_word;
  logic              w_capture;
  logic [ADDR_W-1:0] w_branch_tgt;

`ifdef PC_FETCH_HALT_EN
  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: RUN falls into HALTED on an unredirected zero word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_adv && !w_redirect && w_zero_word) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  assign w_run       = (r_state == ST_RUN);
  assign w_zero_word = (bus.ins == {DATA_W{1'b0}});
  assign bus.halted  = (r_state == ST_HALTED);
`else
  assign w_run       = 1'b1;
  assign w_zero_word = 1'b0;
  assign bus.halted  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Redirect qualification. Redirects originate from decode of ins_out, so
  // they are meaningful only while ins_out is valid. Jump has priority.
  // ---------------------------------------------------------------------------
  assign w_adv        = w_run && !bus.stall;
  assign w_jump       = r_valid && bus.jump;
  assign w_branch     = r_valid && bus.branch_taken && !w_jump;
  assign w_redirect   = w_jump || w_branch;
  assign w_capture    = w_adv && !w_redirect && !w_zero_word;
  assign w_branch_tgt = r_pc_out + bus.branch_offset;

  // Next PC and output-register values
  always_comb begin
    w_pc_nxt        = r_pc;
    w_ins_out_nxt   = r_ins_out;
    w_pc_out_nxt    = r_pc_out;
    w_valid_nxt     = r_valid;
    w_fetch_cnt_nxt = r_fetch_cnt;
    if (w_adv) begin
      if (w_jump) begin
        // Wrong-path word in flight is dropped as a bubble
        w_pc_nxt    = bus.jump_target;
        w_valid_nxt = 1'b0;
      end else if (w_branch) begin
        w_pc_nxt    = w_branch_tgt;
        w_valid_nxt = 1'b0;
      end else if (w_capture) begin
        w_pc_nxt      = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        w_ins_out_nxt = bus.ins;
        w_pc_out_nxt  = r_pc;
        w_valid_nxt   = 1'b1;
        if (r_fetch_cnt != LP_CNT_MAX) begin
          w_fetch_cnt_nxt = r_fetch_cnt + 16'd1;
        end else begin
          w_fetch_cnt_nxt = r_fetch_cnt;
        end
      end else begin
        // Zero word entering HALTED: PC freezes, word is not emitted
        w_valid_nxt = 1'b0;
      end
    end else begin
      w_pc_nxt = r_pc;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= LP_RESET_PC;
      r_ins_out   <= {DATA_W{1'b0}};
      r_pc_out    <= {ADDR_W{1'b0}};
      r_valid     <= 1'b0;
      r_fetch_cnt <= 16'd0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_ins_out   <= w_ins_out_nxt;
      r_pc_out    <= w_pc_out_nxt;
      r_valid     <= w_valid_nxt;
      r_fetch_cnt <= w_fetch_cnt_nxt;
    end
  end

  // Address comes straight from the PC register: no combinational path from
  // the control inputs to the memory.
  assign bus.address   = r_pc;
  assign bus.ins_out   = r_ins_out;
  assign bus.pc_out    = r_pc_out;
  assign bus.valid     = r_valid;
  assign bus.fetch_cnt = r_fetch_cnt;

endmodule : pc_fetch
